// File: rtl/shift_seq_if.sv
// Request/grant/serial bus of the shift sequencer.
// The slave modport is the sequencer. The master modport is whoever drives the
// requests and observes the results.
interface shift_seq_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic             dir0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic             dir1;
    logic [WIDTH-1:0] data1;
    logic             serial_in;
    logic             serial_out;
    logic             shift_left;
    logic             busy;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] data_out;

    modport master (
        output req0, dir0, data0, req1, dir1, data1, serial_in,
        input  serial_out, shift_left, busy, gnt0, gnt1, done0, done1, data_out
    );

    modport slave (
        input  req0, dir0, data0, req1, dir1, data1, serial_in,
        output serial_out, shift_left, busy, gnt0, gnt1, done0, done1, data_out
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Two-requester shift-register sequencer.
// In IDLE, one requester is granted and its word is loaded into the register.
// The register is then shifted for WIDTH cycles with serial_in entering at the
// vacated end. The post-shift word is captured into data_out, and the owner
// sees a one-cycle done pulse.
// Build option: define RR_ARB_EN for round-robin arbitration. When it is left
// undefined, the block uses fixed priority and requester 0 wins.
module shift_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    shift_seq_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shifted;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] data_out_q;
    logic             shift_left_q;
    logic             gnt0_q;
    logic             gnt1_q;

    logic             any_req;
    logic             pick1;      // requester chosen if a grant happens now
    logic             load;
    logic             shift_en;
    logic             capture;

    assign any_req = bus.req0 | bus.req1;

`ifdef RR_ARB_EN
    logic last_gnt1;

    // Round-robin choice: on contention the requester not served last wins.
    always_comb begin
        if (bus.req0 && bus.req1) begin
            pick1 = ~last_gnt1;
        end else begin
            pick1 = bus.req1;
        end
    end

    // Arbitration pointer; it starts as "requester 1 granted last".
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt1 <= 1'b1;
        end else if (load) begin
            last_gnt1 <= pick1;
        end
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle.
    always_comb begin
        pick1 = bus.req1 & ~bus.req0;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking, so all registers
        // update from the same pre-edge values and simulation matches hardware.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        // NOTE: defaults come first so that no path leaves a signal unassigned.
        // An unassigned path in always_comb would infer a latch.
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CNT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One-position shift in the latched direction, with serial_in filling the gap.
    always_comb begin
        if (shift_left_q) begin
            sr_shifted = {sr[WIDTH-2:0], bus.serial_in};
        end else begin
            sr_shifted = {bus.serial_in, sr[WIDTH-1:1]};
        end
    end

    // Shift register, bit counter, result capture, direction and grant flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr           <= '0;
            cnt          <= '0;
            data_out_q   <= '0;
            shift_left_q <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
        end else begin
            if (load) begin
                sr           <= pick1 ? bus.data1 : bus.data0;
                shift_left_q <= pick1 ? bus.dir1 : bus.dir0;
                cnt          <= '0;
                gnt0_q       <= ~pick1;
                gnt1_q       <= pick1;
            end else if (shift_en) begin
                sr  <= sr_shifted;
                cnt <= capture ? '0 : cnt + 1'b1;
                if (capture) begin
                    data_out_q <= sr_shifted;
                end
            end
            // Ownership ends with the DONE cycle.
            if (state == DONE) begin
                gnt0_q <= 1'b0;
                gnt1_q <= 1'b0;
            end
        end
    end

    // Output drive. serial_out only reflects the register while shifting.
    assign bus.serial_out = (state == SHIFT) ? (shift_left_q ? sr[WIDTH-1] : sr[0]) : 1'b0;
    assign bus.shift_left = shift_left_q;
    assign bus.busy       = (state != IDLE);
    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.done0      = (state == DONE) & gnt0_q;
    assign bus.done1      = (state == DONE) & gnt1_q;
    assign bus.data_out   = data_out_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl (WIDTH = 4).
// A transfer-level reference model predicts every output on every cycle.
// Directed transfers add literal expectations on top of that model.
module tb_shift_seq_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_seq_if #(.WIDTH(W)) bus ();

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model tracks the transfer as a phase number:
    //   phase 0         idle
    //   phase 1..W      shift cycle number
    //   phase W+1       done
    // Each expected output is a direct function of that phase.
    int           m_phase = 0;
    bit           m_owner = 1'b0;
    logic         m_dir   = 1'b0;
    logic [W-1:0] m_word  = '0;
    logic [W-1:0] m_bits  = '0;   // serial_in bits, indexed by arrival order
    logic [W-1:0] m_dout  = '0;
    bit           m_last1 = 1'b1;

    // Left shifts push the first arrival up to the MSB. Right shifts push it down to the LSB.
    function automatic logic [W-1:0] assemble(input logic [W-1:0] b, input logic d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d ? b[W-1-i] : b[i];
        return r;
    endfunction

    function automatic bit choose1(input logic r0, input logic r1, input bit last1);
`ifdef RR_ARB_EN
        if (r0 && r1) return ~last1;
        return r1;
`else
        return !r0;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_dir   <= 1'b0;
            m_dout  <= '0;
            m_last1 <= 1'b1;
        end else if (m_phase == 0) begin
            if (bus.req0 || bus.req1) begin
                m_owner <= choose1(bus.req0, bus.req1, m_last1);
                m_last1 <= choose1(bus.req0, bus.req1, m_last1);
                m_dir   <= choose1(bus.req0, bus.req1, m_last1) ? bus.dir1 : bus.dir0;
                m_word  <= choose1(bus.req0, bus.req1, m_last1) ? bus.data1 : bus.data0;
                m_phase <= 1;
            end
        end else if (m_phase <= W) begin
            m_bits[m_phase-1] <= bus.serial_in;
            if (m_phase == W) m_dout <= assemble({bus.serial_in, m_bits[W-2:0]}, m_dir);
            m_phase <= m_phase + 1;
        end else begin
            m_phase <= 0;
        end
    end

    function automatic logic exp_serial_out();
        if (m_phase < 1 || m_phase > W) return 1'b0;
        return m_dir ? m_word[W-m_phase] : m_word[m_phase-1];
    endfunction

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("serial_out", 32'(bus.serial_out), 32'(exp_serial_out()));
            check("shift_left", 32'(bus.shift_left), 32'(m_dir));
            check("busy",       32'(bus.busy),       32'(m_phase != 0));
            check("gnt0",       32'(bus.gnt0),       32'(m_phase != 0 && !m_owner));
            check("gnt1",       32'(bus.gnt1),       32'(m_phase != 0 && m_owner));
            check("done0",      32'(bus.done0),      32'(m_phase == W + 1 && !m_owner));
            check("done1",      32'(bus.done1),      32'(m_phase == W + 1 && m_owner));
            check("data_out",   32'(bus.data_out),   32'(m_dout));
            check("gnt_mutex",  32'(bus.gnt0 & bus.gnt1), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete transfer from IDLE and checks literal expectations.
    // sin[i] and exp_so[i] belong to shift cycle i.
    task automatic xfer(input bit who, input logic d, input logic [W-1:0] word,
                        input logic [W-1:0] sin, input logic [W-1:0] exp_so,
                        input logic [W-1:0] exp_dout, input string tag);
        logic [W-1:0] so;
        if (who) begin
            bus.req1 = 1'b1; bus.dir1 = d; bus.data1 = word;
        end else begin
            bus.req0 = 1'b1; bus.dir0 = d; bus.data0 = word;
        end
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check({tag, "_gnt0"}, 32'(bus.gnt0), 32'(!who));
        check({tag, "_gnt1"}, 32'(bus.gnt1), 32'(who));
        for (int i = 0; i < W; i++) begin
            bus.serial_in = sin[i];
            @(negedge clk);
            so[i] = bus.serial_out;
            tick();
        end
        check({tag, "_serial_seq"}, 32'(so), 32'(exp_so));
        check({tag, "_done"}, 32'(who ? bus.done1 : bus.done0), 32'd1);
        check({tag, "_data_out"}, 32'(bus.data_out), 32'(exp_dout));
        tick();
        check({tag, "_idle"}, 32'({bus.busy, bus.done0, bus.done1}), 32'd0);
    endtask

    initial begin
        int n;
        logic [2:0] grants;
        logic [2:0] exp_grants;

        bus.req0 = 1'b0; bus.dir0 = 1'b0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.dir1 = 1'b0; bus.data1 = '0;
        bus.serial_in = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_data_out", 32'(bus.data_out), 32'd0);
        check("reset_flags", 32'({bus.busy, bus.gnt0, bus.gnt1, bus.shift_left}), 32'd0);

        // Requester 0 shifts left with serial_in held at 1.
        xfer(1'b0, 1'b1, 4'b1010, 4'b1111, 4'b0101, 4'b1111, "left_r0");
        // Requester 1 shifts right with serial_in 1,0,0,1.
        xfer(1'b1, 1'b0, 4'b0011, 4'b1001, 4'b0011, 4'b1001, "right_r1");

        // Both requests held high for three transfers.
        bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.data0 = 4'b0110;
        bus.req1 = 1'b1; bus.dir1 = 1'b0; bus.data1 = 4'b1001;
        bus.serial_in = 1'b0;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            while (!(bus.gnt0 || bus.gnt1) && n < 20) begin tick(); n++; end
            grants[t] = bus.gnt1;
            n = 0;
            while (bus.busy && n < 20) begin tick(); n++; end
            if (n >= 20) check("contend_timeout", 32'd1, 32'd0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
`ifdef RR_ARB_EN
        exp_grants = 3'b010;
`else
        exp_grants = 3'b000;
`endif
        check("contend_grants", 32'(grants), 32'(exp_grants));

        // Reset on the second shift cycle aborts the transfer.
        bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.data0 = 4'b1111;
        tick();
        bus.req0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_flags", 32'({bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                                  bus.serial_out, bus.shift_left}), 32'd0);
        check("abort_data_out", 32'(bus.data_out), 32'd0);
        xfer(1'b0, 1'b0, 4'b1100, 4'b1011, 4'b1100, 4'b1011, "after_abort");

        // Requester 0 drops its request after the grant. Requester 1 rises during SHIFT.
        bus.req0 = 1'b1; bus.dir0 = 1'b0; bus.data0 = 4'b0101;
        bus.serial_in = 1'b1;
        tick();
        bus.req0 = 1'b0;
        tick();
        n = 1;
        bus.req1 = 1'b1; bus.dir1 = 1'b1; bus.data1 = 4'b0001;
        while (!bus.gnt1 && n < 20) begin tick(); n++; end
        check("late_req1_grant_edge", 32'(n), 32'(W + 2));
        bus.req1 = 1'b0;
        n = 0;
        while (bus.busy && n < 20) begin tick(); n++; end
        if (n >= 20) check("late_req1_timeout", 32'd1, 32'd0);
        check("late_req1_data_out", 32'(bus.data_out), 32'(4'b1111));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
